// File: rtl/fx_arb_pkg.sv
// Shared constants and fixed-point helpers for the requantization arbiter.
// fx_quant/fx_ovf operate on sign-extended 64-bit values so any parameterisation can reuse them.
package fx_arb_pkg;

  localparam int unsigned N_REQ_D = 4;
  localparam int unsigned IW_D    = 17;
  localparam int unsigned SHIFT_D = 2;
  localparam int unsigned OW_D    = 12;
  localparam int unsigned LAT_D   = 1;
  localparam int unsigned CNT_W_D = 16;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when q does not fit in an ow-bit signed word.
  function automatic logic fx_ovf(input logic signed [63:0] q, input int unsigned ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    return (q > hi) || (q < lo);
  endfunction

  // Caller truncates the result to ow bits; with sat=0 this is plain wrap-around.
  function automatic logic [63:0] fx_quant(input logic signed [63:0] q, input int unsigned ow,
                                           input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sat && fx_ovf(q, ow)) return q[63] ? lo : hi;
    return q;
  endfunction

endpackage

// File: rtl/fx_arb_rr.sv
// Round-robin grant: first asserted request at or after ptr, wrapping modulo N.
module fx_arb_rr
  import fx_arb_pkg::*;
#(
  parameter int unsigned N  = N_REQ_D,
  parameter int unsigned TW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] ptr_i,
  output logic [TW-1:0] gnt_c_o,
  output logic          any_c_o
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_c_o = '0;
    idx     = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = (32'(ptr_i) + 32'(i)) % N;
      if (req_i[idx]) gnt_c_o = TW'(idx);
    end
  end

  assign any_c_o = |req_i;

endmodule

// File: rtl/fx_match_arbiter.sv
// Round-robin shared requantizer (arith shift, overflow flag, LAT-stage pipeline, valid/ready out).
// Define FXARB_SAT_EN to saturate overflowed results instead of wrapping.
module fx_match_arbiter
  import fx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_D,
  parameter int unsigned IW    = IW_D,
  parameter int unsigned SHIFT = SHIFT_D,
  parameter int unsigned OW    = OW_D,
  parameter int unsigned LAT   = LAT_D,
  parameter int unsigned CNT_W = CNT_W_D
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            i_valid,
  input  logic [N_REQ*IW-1:0]         i_data,
  output logic [N_REQ-1:0]            o_ready,
  input  logic                        i_out_rdy,
  output logic                        o_valid,
  output logic [OW-1:0]               o_data,
  output logic [clog2_min1(N_REQ)-1:0] o_tag,
  output logic                        o_ovf,
  output logic [CNT_W-1:0]            o_ovf_cnt
);

  localparam int unsigned TW = clog2_min1(N_REQ);
  localparam int unsigned QW = IW - SHIFT;

  logic [TW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    gnt;
  logic             any;
  logic             advance;
  logic             accept;
  logic signed [IW-1:0] din;
  logic signed [QW-1:0] q_s;
  logic [OW-1:0]    s0_data;
  logic             s0_ovf;
  logic             vld_q [LAT];
  logic [OW-1:0]    dat_q [LAT];
  logic [TW-1:0]    tag_q [LAT];
  logic             ovf_q [LAT];
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  fx_arb_rr #(.N(N_REQ), .TW(TW)) u_rr (
    .req_i   (i_valid),
    .ptr_i   (ptr_q),
    .gnt_c_o (gnt),
    .any_c_o (any)
  );

  assign advance = ~(vld_q[LAT-1] & ~i_out_rdy);
  assign accept  = advance & any;
  assign ptr_d   = (gnt == TW'(N_REQ - 1)) ? '0 : gnt + TW'(1);

  always_comb begin
    o_ready      = '0;
    o_ready[gnt] = accept;
  end

  // Quantize the granted lane: arithmetic shift, then wrap or saturate into OW bits.
  always_comb begin
    din    = i_data[int'(gnt)*IW +: IW];
    q_s    = QW'(din >>> SHIFT);
    s0_ovf = fx_ovf(64'(q_s), OW);
`ifdef FXARB_SAT_EN
    s0_data = OW'(fx_quant(64'(q_s), OW, 1'b1));
`else
    s0_data = OW'(q_s);
`endif
  end

  assign cnt_inc = vld_q[LAT-1] & i_out_rdy & ovf_q[LAT-1] & ~(&cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int s = 0; s < int'(LAT); s++) begin
        vld_q[s] <= 1'b0;
        dat_q[s] <= '0;
        tag_q[s] <= '0;
        ovf_q[s] <= 1'b0;
      end
    end else begin
      if (accept) ptr_q <= ptr_d;
      // Whole pipeline moves together; an empty input slot becomes a bubble.
      if (advance) begin
        vld_q[0] <= accept;
        dat_q[0] <= s0_data;
        tag_q[0] <= gnt;
        ovf_q[0] <= s0_ovf;
        for (int s = 1; s < int'(LAT); s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
          tag_q[s] <= tag_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_valid   = vld_q[LAT-1];
  assign o_data    = dat_q[LAT-1];
  assign o_tag     = tag_q[LAT-1];
  assign o_ovf     = ovf_q[LAT-1];
  assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_fx_match_arbiter.sv
// Directed + scoreboard bench for fx_match_arbiter (N_REQ=4, IW=17, SHIFT=2, OW=12, LAT=1).
module tb_fx_match_arbiter;
  import fx_arb_pkg::*;

  localparam int N     = 4;
  localparam int IW    = 17;
  localparam int SHIFT = 2;
  localparam int OW    = 12;
  localparam int CNT_W = 16;
  localparam int TW    = 2;
`ifdef FXARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [OW-1:0] d;
    logic [TW-1:0] t;
    logic          o;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      i_valid;
  logic [N*IW-1:0]   i_data;
  logic [N-1:0]      o_ready;
  logic              i_out_rdy;
  logic              o_valid;
  logic [OW-1:0]     o_data;
  logic [TW-1:0]     o_tag;
  logic              o_ovf;
  logic [CNT_W-1:0]  o_ovf_cnt;

  exp_t              sb[$];
  int unsigned       m_ptr;
  logic [CNT_W-1:0]  m_cnt;
  bit                m_ovalid;
  logic [N-1:0]      m_last_er;
  int                n_assert = 0;
  int                n_fail   = 0;

  fx_match_arbiter #(.N_REQ(N), .IW(IW), .SHIFT(SHIFT), .OW(OW), .LAT(1), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .i_out_rdy (i_out_rdy),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_tag     (o_tag),
    .o_ovf     (o_ovf),
    .o_ovf_cnt (o_ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_q(input logic [IW-1:0] raw, input int tag);
    exp_t e;
    logic signed [IW-1:0]       v;
    logic signed [IW-SHIFT-1:0] q;
    v   = raw;
    q   = (IW-SHIFT)'(v >>> SHIFT);
    e.d = OW'(fx_quant(64'(q), OW, SAT));
    e.o = fx_ovf(64'(q), OW);
    e.t = TW'(tag);
    return e;
  endfunction

  task automatic set_req(input int n, input logic [IW-1:0] val);
    i_data[n*IW +: IW] = val;
  endtask

  // Check current cycle against the model, then advance the model and the clock by one cycle.
  task automatic step(input bit chk_on);
    logic [N-1:0] er;
    int           g;
    bit           stall_m;
    exp_t         e;
    #1;
    stall_m = m_ovalid && !i_out_rdy;
    g = 0;
    for (int k = N - 1; k >= 0; k--)
      if (i_valid[(int'(m_ptr) + k) % N]) g = (int'(m_ptr) + k) % N;
    er = (!stall_m && (|i_valid)) ? (N'(1) << g) : '0;
    if (chk_on) begin
      chk("o_ready", 64'(o_ready), 64'(er));
      chk("o_valid", 64'(o_valid), 64'(m_ovalid));
      if (m_ovalid && sb.size() > 0) begin
        chk("o_data", 64'(o_data), 64'(sb[0].d));
        chk("o_tag",  64'(o_tag),  64'(sb[0].t));
        chk("o_ovf",  64'(o_ovf),  64'(sb[0].o));
      end
      chk("o_ovf_cnt", 64'(o_ovf_cnt), 64'(m_cnt));
    end
    if (m_ovalid && i_out_rdy && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.o && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    if (er != '0) begin
      sb.push_back(model_q(i_data[g*IW +: IW], g));
      m_ptr = (g + 1) % N;
    end
    m_last_er = er;
    m_ovalid  = sb.size() > 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = '0; i_data = '0; i_out_rdy = 1'b1;
    m_ptr = 0; m_cnt = '0; m_ovalid = 1'b0; m_last_er = '0;
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_data",  64'(o_data),  64'd0);
    chk("rst_o_cnt",   64'(o_ovf_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single requests through the quantizer.
    i_valid = 4'b0010; set_req(1, 17'h00FFC);
    step(1);
    i_valid = '0;
    #1;
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_data",  64'(o_data),  64'h3FF);
    chk("t1_tag",   64'(o_tag),   64'd1);
    chk("t1_ovf",   64'(o_ovf),   64'd0);
    step(1);

    i_valid = 4'b0001; set_req(0, 17'h1FFFD);
    step(1);
    i_valid = '0;
    #1;
    chk("t2_data", 64'(o_data), 64'hFFF);
    chk("t2_ovf",  64'(o_ovf),  64'd0);
    step(1);

    i_valid = 4'b0100; set_req(2, 17'h02000);
    step(1);
    i_valid = '0;
    #1;
    chk("t3_ovf",  64'(o_ovf), 64'd1);
    chk("t3_data", 64'(o_data), SAT ? 64'h7FF : 64'h800);
    chk("t3_cnt0", 64'(o_ovf_cnt), 64'd0);
    step(1);
    chk("t3_cnt1", 64'(o_ovf_cnt), 64'd1);

    // Reset with one sample in flight.
    i_valid = 4'b1000; set_req(3, 17'h00123);
    step(1);
    i_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", 64'(o_valid), 64'd0);
    chk("rst2_data",  64'(o_data),  64'd0);
    chk("rst2_tag",   64'(o_tag),   64'd0);
    chk("rst2_cnt",   64'(o_ovf_cnt), 64'd0);
    sb.delete(); m_ptr = 0; m_cnt = '0; m_ovalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters active: rotation 0,1,2,3,0... then a 3-cycle downstream stall.
    i_valid = 4'b1111;
    for (int n = 0; n < N; n++) set_req(n, IW'(n * 1000 + 4));
    #1;
    chk("t6_first_grant", 64'(o_ready), 64'b0001);
    for (int c = 0; c < 6; c++) step(1);
    i_out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) step(1);
    i_out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) step(1);

    // Randomised traffic with requesters holding data until accepted.
    for (int c = 0; c < 80; c++) begin
      for (int n = 0; n < N; n++)
        if (!i_valid[n] || m_last_er[n]) begin
          i_valid[n] = 1'($urandom_range(0, 1));
          set_req(n, IW'($urandom));
        end
      i_out_rdy = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Saturate the overflow counter with a long overflowing stream.
    i_out_rdy = 1'b1;
    i_valid = 4'b1111;
    for (int n = 0; n < N; n++) set_req(n, 17'h0FFFF);
    for (int c = 0; c < 65540; c++) step(0);
    step(1);
    step(1);
    chk("cnt_sat", 64'(o_ovf_cnt), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
